// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - ID/EX pipeline register bus: ID-side capture inputs and EX-side registered outputs.
// The bubble counter port exists only when IDEX_BUBBLE_CNT_EN is defined.
interface id_ex_reg_if #(
  parameter int CTRL_W = 16
);
  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [31:0]       id_pc_i;
  logic [31:0]       id_instr_i;
  logic [31:0]       id_rs_data_i;
  logic [31:0]       id_rt_data_i;
  logic [31:0]       id_ext_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [4:0]        id_wreg_i;

  logic              ex_valid_o;
  logic [31:0]       ex_pc_o;
  logic [31:0]       ex_instr_o;
  logic [31:0]       ex_rs_data_o;
  logic [31:0]       ex_rt_data_o;
  logic [31:0]       ex_ext_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [4:0]        ex_wreg_o;
  logic [4:0]        ex_rs_num_o;
  logic [4:0]        ex_rt_num_o;
  logic              load_use_o;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]       bubble_cnt_o;
`endif

  modport master (
    output hold_i, flush_i, id_valid_i, id_pc_i, id_instr_i,
    output id_rs_data_i, id_rt_data_i, id_ext_i, id_ctrl_i, id_wreg_i,
    input  ex_valid_o, ex_pc_o, ex_instr_o, ex_rs_data_o, ex_rt_data_o,
    input  ex_ext_o, ex_ctrl_o, ex_wreg_o, ex_rs_num_o, ex_rt_num_o,
    input  load_use_o
`ifdef IDEX_BUBBLE_CNT_EN
    , input bubble_cnt_o
`endif
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_pc_i, id_instr_i,
    input  id_rs_data_i, id_rt_data_i, id_ext_i, id_ctrl_i, id_wreg_i,
    output ex_valid_o, ex_pc_o, ex_instr_o, ex_rs_data_o, ex_rt_data_o,
    output ex_ext_o, ex_ctrl_o, ex_wreg_o, ex_rs_num_o, ex_rt_num_o,
    output load_use_o
`ifdef IDEX_BUBBLE_CNT_EN
    , output bubble_cnt_o
`endif
  );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with hold, flush/bubble insertion and load-use detection.
// Optional saturating bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_reg #(
  parameter int CTRL_W       = 16,
  parameter int MEMREAD_BIT  = 3,
  parameter int REGWRITE_BIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_reg_if.slave  bus
);

  generate
    if ((MEMREAD_BIT >= CTRL_W) || (REGWRITE_BIT >= CTRL_W)) begin : g_bad_cfg
      $error("id_ex_reg: control bit index outside control word");
    end
  endgenerate

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_rs_data;
  logic [31:0]       r_rt_data;
  logic [31:0]       r_ext;
  logic [CTRL_W-1:0] r_ctrl;
  logic [4:0]        r_wreg;
  logic [4:0]        r_rs_num;
  logic [4:0]        r_rt_num;

  logic w_bubble;
  logic w_load;
  logic w_rs_hit;
  logic w_rt_hit;

  // An empty ID slot becomes a bubble, so EX never sees a stale control word.
  assign w_bubble = bus.flush_i | (~bus.hold_i & ~bus.id_valid_i);
  assign w_load   = ~bus.flush_i & ~bus.hold_i & bus.id_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= 32'd0;
      r_instr   <= 32'd0;
      r_rs_data <= 32'd0;
      r_rt_data <= 32'd0;
      r_ext     <= 32'd0;
      r_ctrl    <= '0;
      r_wreg    <= 5'd0;
      r_rs_num  <= 5'd0;
      r_rt_num  <= 5'd0;
    end else if (w_bubble) begin
      r_valid  <= 1'b0;
      r_instr  <= 32'd0;
      r_ctrl   <= '0;
      r_wreg   <= 5'd0;
      r_rs_num <= 5'd0;
      r_rt_num <= 5'd0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_pc      <= bus.id_pc_i;
      r_instr   <= bus.id_instr_i;
      r_rs_data <= bus.id_rs_data_i;
      r_rt_data <= bus.id_rt_data_i;
      r_ext     <= bus.id_ext_i;
      r_ctrl    <= bus.id_ctrl_i;
      r_wreg    <= bus.id_wreg_i;
      r_rs_num  <= bus.id_instr_i[25:21];
      r_rt_num  <= bus.id_instr_i[20:16];
    end
  end

  assign bus.ex_valid_o   = r_valid;
  assign bus.ex_pc_o      = r_pc;
  assign bus.ex_instr_o   = r_instr;
  assign bus.ex_rs_data_o = r_rs_data;
  assign bus.ex_rt_data_o = r_rt_data;
  assign bus.ex_ext_o     = r_ext;
  assign bus.ex_ctrl_o    = r_ctrl;
  assign bus.ex_wreg_o    = r_wreg;
  assign bus.ex_rs_num_o  = r_rs_num;
  assign bus.ex_rt_num_o  = r_rt_num;

  // A load writing $0 never produces a result, so it cannot create a hazard.
  assign w_rs_hit = (r_wreg == bus.id_instr_i[25:21]);
  assign w_rt_hit = (r_wreg == bus.id_instr_i[20:16]);
  assign bus.load_use_o = bus.id_valid_i & r_valid & r_ctrl[MEMREAD_BIT] &
                          (r_wreg != 5'd0) & (w_rs_hit | w_rt_hit);

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bus.bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage (register file read, immediate extender, control decode) and the execute stage of the 5-stage MIPS pipeline.
- Captures each decoded instruction together with its extended immediate, operand data, control word and destination register number.
- Supports hold (back-pressure from EX and later stages) and flush (bubble insertion for load-use and redirect).
- Produces the load-use hazard flag that the stall unit consumes.

Parameters:
- CTRL_W, 16, width of the decoded control word carried to EX.
- MEMREAD_BIT, 3, index in the control word of the "instruction reads memory" (load) flag.
- REGWRITE_BIT, 0, index in the control word of the register-write-enable flag.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: synchronous, active-high reset.
- hold_i in 1: keep current contents.
- flush_i in 1: load a bubble on the next edge.
- id_valid_i in 1: the ID stage holds a real instruction.
- id_pc_i in 32: PC of the ID instruction.
- id_instr_i in 32: raw instruction word.
- id_rs_data_i in 32: register file read port A.
- id_rt_data_i in 32: register file read port B.
- id_ext_i in 32: extended immediate / shamt from the extender.
- id_ctrl_i in CTRL_W: decoded control word.
- id_wreg_i in 5: destination register number.
- ex_valid_o out 1: EX holds a real instruction.
- ex_pc_o out 32: registered PC.
- ex_instr_o out 32: registered instruction word.
- ex_rs_data_o out 32: registered operand A.
- ex_rt_data_o out 32: registered operand B.
- ex_ext_o out 32: registered immediate.
- ex_ctrl_o out CTRL_W: registered control word.
- ex_wreg_o out 5: registered destination register.
- ex_rs_num_o out 5: instr[25:21] of the EX instruction.
- ex_rt_num_o out 5: instr[20:16] of the EX instruction.
- load_use_o out 1: load-use hazard flag (combinational).

Behaviour:
- Clocking and reset: single clock domain, all state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: every output register is 0 (ex_valid_o=0, ex_ctrl_o=0, ex_wreg_o=0, all data fields 0).
- Priority on each edge: rst > flush_i > hold_i > load.
- Flush: ex_valid_o←0, ex_ctrl_o←0, ex_wreg_o←0, ex_instr_o←0 (NOP), ex_rs_num_o/ex_rt_num_o←0. Data and PC fields may keep their old values or take new ones; they must never be used when ex_valid_o=0. The bench does not check them.
- Hold (flush_i=0): all registers keep their values.
- Load (flush_i=0, hold_i=0, id_valid_i=1): all fields are captured from the id_* inputs. ex_rs_num_o=id_instr_i[25:21], ex_rt_num_o=id_instr_i[20:16]. ex_valid_o←1.
- Load with id_valid_i=0: treated exactly as a flush (bubble). An invalid slot never carries a nonzero control word.
- Latency: exactly 1 cycle from ID inputs to EX outputs. There are no combinational paths from id_* inputs to ex_* outputs.
- flush_i and hold_i asserted together: flush wins and a bubble is loaded.
- rst asserted during hold or flush: the register still resets on that edge.
- load_use_o = ex_valid_o & ex_ctrl_o[MEMREAD_BIT] & (ex_wreg_o≠0) & ((ex_wreg_o==id_instr_i[25:21]) | (ex_wreg_o==id_instr_i[20:16])). It is gated low when id_valid_i=0. This is the only combinational output.
- The data path is width-preserving. No arithmetic is performed inside the block.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- When defined:
  - Adds output port bubble_cnt_o out 32, reset to 0.
  - Increments by 1 on every edge (rst=0) on which a bubble is loaded, by flush_i=1 or by load with id_valid_i=0.
  - Does not change during hold without flush.
  - Saturates at 32'hFFFFFFFF.
- When undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with id_* driven to nonzero values -> all ex_* = 0, ex_valid_o=0, load_use_o=0.
- Plain load: id_valid_i=1, id_pc_i=32'h00000040, id_instr_i=32'h2128FFFF (addi $8,$9,-1), id_ext_i=32'hFFFFFFFF, id_ctrl_i=16'h0001, id_wreg_i=8 -> next cycle ex_pc_o=32'h40, ex_ext_o=32'hFFFFFFFF, ex_rs_num_o=9, ex_rt_num_o=8, ex_wreg_o=8, ex_valid_o=1.
- Hold: after the load, hold_i=1 for 3 cycles while the id_* values change -> ex_* stay unchanged. Release hold -> the new values appear 1 cycle later.
- Flush beats hold: hold_i=1 and flush_i=1 together -> next cycle ex_valid_o=0, ex_ctrl_o=0, ex_wreg_o=0, ex_instr_o=0.
- Load-use: EX holds lw $8 (ctrl[3]=1, ex_wreg_o=8) and ID holds add $10,$8,$9 (id_instr_i=32'h01095020, id_valid_i=1) -> load_use_o=1. Set id_valid_i=0 -> load_use_o=0. EX holding lw $0 -> load_use_o=0.
- With IDEX_BUBBLE_CNT_EN defined: 5 flushes plus 2 loads with id_valid_i=0 plus 3 hold-only cycles -> bubble_cnt_o=7. Preload the counter to 32'hFFFFFFFE via a forced sequence, then 3 bubbles -> bubble_cnt_o stays at 32'hFFFFFFFF.
